led_blink_ctrl: RTL

Configuration controller for a bank of LED blink counters. Accepts divide-ratio requests over a valid/ready handshake and computes each channel's terminal count (`CNT_1S / div`) on one shared serial divider. It then writes the result to that channel's `cnt_max` register and pulses the channel's restart strobe. It sits between the PS-side register interface and the per-channel blink counters, which consume `cnt_max_o` and `wren_o`.

---
 rtl/led_ctrl_pkg.sv | 24 ++
 rtl/serial_div.sv | 76 +++++++
 rtl/led_blink_ctrl.sv | 96 +++++++++
 3 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared constants and types for the LED blink configuration controller.
package led_ctrl_pkg;

  localparam int CNT_W = 28;
  localparam int DIV_W = 5;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t             CNT_1S  = 28'h5F5E100;
  localparam logic [DIV_W-1:0] DIV_MAX = 5'd20;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    WRITE,
    SYNC
  } ctrl_state_t;

  // Ratios of zero or above DIV_MAX fall back to the one-second default.
  function automatic logic div_bypass(input logic [DIV_W-1:0] div);
    return (div == '0) || (div > DIV_MAX);
  endfunction

endpackage

// File: rtl/serial_div.sv
// Restoring serial divider: one quotient bit per cycle, MSB first, CNT_W cycles.
module serial_div
  import led_ctrl_pkg::*;
(
  input  logic             clk100,
  input  logic             rst,
  input  logic             start_i,
  input  cnt_t             dividend_i,
  input  logic [DIV_W-1:0] divisor_i,
  output logic             done_o,
  output cnt_t             quotient_o
);

  logic           run_q, run_d;
  logic [4:0]     iter_q, iter_d;
  logic [CNT_W:0] rem_q, rem_d;
  logic [CNT_W:0] dvs_q, dvs_d;
  cnt_t           quo_q, quo_d;
  logic [CNT_W:0] trial, diff;
  logic           last;

  // The quotient register doubles as the dividend shifter: dividend bits
  // leave at the top while quotient bits enter at the bottom.
  assign trial      = {rem_q[CNT_W-1:0], quo_q[CNT_W-1]};
  assign diff       = trial - dvs_q;
  assign last       = run_q && (iter_q == 5'(CNT_W - 1));
  assign done_o     = last;
  assign quotient_o = quo_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves a latch.
    run_d  = run_q;
    iter_d = iter_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    quo_d  = quo_q;
    if (start_i) begin
      run_d  = 1'b1;
      iter_d = '0;
      rem_d  = '0;
      dvs_d  = {{(CNT_W + 1 - DIV_W){1'b0}}, divisor_i};
      quo_d  = dividend_i;
    end else if (run_q) begin
      if (diff[CNT_W]) begin
        rem_d = trial;
        quo_d = {quo_q[CNT_W-2:0], 1'b0};
      end else begin
        rem_d = diff;
        quo_d = {quo_q[CNT_W-2:0], 1'b1};
      end
      iter_d = iter_q + 5'd1;
      if (last) run_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours.
  always_ff @(posedge clk100) begin
    if (rst) begin
      run_q  <= 1'b0;
      iter_q <= '0;
    end else begin
      run_q  <= run_d;
      iter_q <= iter_d;
    end
  end

  // NOTE: the datapath is left unreset; it is always reloaded by start_i
  // before anything reads it.
  always_ff @(posedge clk100) begin
    rem_q <= rem_d;
    dvs_q <= dvs_d;
    quo_q <= quo_d;
  end

endmodule

// File: rtl/led_blink_ctrl.sv
// Configuration controller: turns divide-ratio requests into per-channel
// terminal counts using one shared serial divider, then strobes a restart.
module led_blink_ctrl
  import led_ctrl_pkg::*;
#(
  parameter  int NCH  = 4,
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk100,
  input  logic                 rst,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [CH_W-1:0]      req_ch_i,
  input  logic [DIV_W-1:0]     req_div_i,
  input  logic                 req_all_i,
  output logic [NCH*CNT_W-1:0] cnt_max_o,
  output logic [NCH-1:0]       wren_o,
  output logic                 busy_o
);

  ctrl_state_t     state_q, state_d;
  logic [CH_W-1:0] ch_q;
  logic            all_q;
  logic            bypass_q;
  cnt_t            cnt_max_q [NCH];
  logic [NCH-1:0]  wren_q;
  logic [NCH-1:0]  sel;
  logic            accept;
  logic            bypass;
  logic            div_start;
  logic            div_done;
  cnt_t            quotient;
  cnt_t            result;

  assign req_ready_o = (state_q == IDLE) && !rst;
  assign accept      = req_valid_i && req_ready_o;
  assign bypass      = div_bypass(req_div_i);
  assign div_start   = accept && !bypass;
  assign result      = bypass_q ? CNT_1S : quotient;
  assign busy_o      = (state_q != IDLE);
  assign wren_o      = wren_q;

  serial_div u_div (
    .clk100     (clk100),
    .rst        (rst),
    .start_i    (div_start),
    .dividend_i (CNT_1S),
    .divisor_i  (req_div_i),
    .done_o     (div_done),
    .quotient_o (quotient)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = bypass ? WRITE : DIV;
      DIV:     if (div_done) state_d = WRITE;
      WRITE:   state_d = SYNC;
      SYNC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // An out-of-range channel index matches no k, so nothing is written.
  always_comb begin
    sel = '0;
    for (int k = 0; k < NCH; k++)
      sel[k] = (state_q == WRITE) && (all_q || (int'(ch_q) == k));
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      state_q <= IDLE;
      wren_q  <= '0;
      for (int k = 0; k < NCH; k++) cnt_max_q[k] <= CNT_1S;
    end else begin
      state_q <= state_d;
      wren_q  <= sel;
      for (int k = 0; k < NCH; k++)
        if (sel[k]) cnt_max_q[k] <= result;
    end
  end

  always_ff @(posedge clk100) begin
    if (accept) begin
      ch_q     <= req_ch_i;
      all_q    <= req_all_i;
      bypass_q <= bypass;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_pack
    assign cnt_max_o[k*CNT_W +: CNT_W] = cnt_max_q[k];
  end

endmodule
